// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: feeds a parallel word MSB-first into a serial 1-1-0-1 Mealy
// detector, clearing the detector first, and collects the match results
// (found flag, position of the first match, saturating match count).

module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int POS_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             w_out,
    output logic             det_reset,
    input  logic             z_in,
    output logic             done,
    output logic             found,
    output logic [POS_W-1:0] first_pos,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the final shift cycle; the scan leaves SHIFT after this bit.
    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [POS_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [POS_W-1:0] first_pos_q, first_pos_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;

    // Match counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Next-state and result update logic for the scan sequence.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        found_d       = found_q;
        first_pos_d   = first_pos_q;
        match_count_d = match_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    shift_d = data_in;
                end
            end
            CLEAR: begin
                // Results from the previous scan are dropped only here, so
                // they stay readable through DONE and the following IDLE.
                state_d       = SHIFT;
                idx_d         = '0;
                found_d       = 1'b0;
                first_pos_d   = '0;
                match_count_d = '0;
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                idx_d   = idx_q + POS_W'(1);
                // z_in is Mealy: it answers the bit presented in this cycle.
                if (z_in) begin
                    match_count_d = sat_inc(match_count_q);
                    if (!found_q) begin
                        found_d     = 1'b1;
                        first_pos_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CLEAR) || (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // Control state and result registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            first_pos_q   <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            first_pos_q   <= first_pos_d;
            match_count_q <= match_count_d;
        end
    end

    // Shift register holds data only; it is always reloaded before use.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

    assign w_out       = (state_q == SHIFT) ? shift_q[WIDTH-1] : 1'b0;
    assign det_reset   = reset || (state_q == CLEAR);
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign first_pos   = first_pos_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl: two instances (default 8-bit and a 16-bit,
// 2-bit-count variant), each wired to a behavioural 1-1-0-1 Mealy detector.
// Expected results come from a reference scan pushed into a scoreboard.

module tb_seq_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [7:0]  data_a = '0;
    logic [15:0] data_b = '0;

    logic        busy_a, w_a, det_a, z_a, done_a, found_a;
    logic [2:0]  first_pos_a;
    logic [3:0]  match_count_a;
    logic        busy_b, w_b, det_b, z_b, done_b, found_b;
    logic [3:0]  first_pos_b;
    logic [1:0]  match_count_b;

    logic [1:0]  st_a = 2'd0;
    logic [1:0]  st_b = 2'd0;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit found;
        int pos;
        int cnt;
    } res_t;
    res_t sb_q[$];

    // Per-scan log filled by scan_a
    int          done_cyc;
    logic        done_after;
    logic [39:0] w_log, dr_log, busy_log;

    always #5 clock = ~clock;

    seq_scan_ctrl #(.WIDTH(8), .POS_W(3), .CNT_W(4)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .data_in(data_a),
        .busy(busy_a), .w_out(w_a), .det_reset(det_a), .z_in(z_a),
        .done(done_a), .found(found_a), .first_pos(first_pos_a),
        .match_count(match_count_a)
    );

    seq_scan_ctrl #(.WIDTH(16), .POS_W(4), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .data_in(data_b),
        .busy(busy_b), .w_out(w_b), .det_reset(det_b), .z_in(z_b),
        .done(done_b), .found(found_b), .first_pos(first_pos_b),
        .match_count(match_count_b)
    );

    // 1-1-0-1 Mealy detector: 0 idle, 1 saw 1, 2 saw 11, 3 saw 110; no overlap
    function automatic logic [1:0] det_next(input logic [1:0] st, input logic w);
        case (st)
            2'd0: return w ? 2'd1 : 2'd0;
            2'd1: return w ? 2'd2 : 2'd0;
            2'd2: return w ? 2'd2 : 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign z_a = (st_a == 2'd3) && w_a;
    assign z_b = (st_b == 2'd3) && w_b;

    always @(posedge clock) begin
        st_a <= det_a ? 2'd0 : det_next(st_a, w_a);
        st_b <= det_b ? 2'd0 : det_next(st_b, w_b);
    end

    function automatic res_t ref_scan(input logic [15:0] word, input int width, input int cmax);
        res_t r;
        logic [1:0] st;
        logic w;
        r.found = 1'b0;
        r.pos = 0;
        r.cnt = 0;
        st = 2'd0;
        for (int k = 0; k < width; k++) begin
            w = word[width-1-k];
            if (st == 2'd3 && w) begin
                if (r.cnt < cmax) r.cnt = r.cnt + 1;
                if (!r.found) begin
                    r.found = 1'b1;
                    r.pos = k;
                end
            end
            st = det_next(st, w);
        end
        return r;
    endfunction

    // Drives one scan on instance A and logs per-cycle outputs; start is
    // re-pulsed with a different word in cycles p1/p2 (cycle 1 = CLEAR).
    task automatic scan_a(input logic [7:0] word, input int p1, input int p2);
        @(negedge clock);
        data_a = word;
        start_a = 1'b1;
        done_cyc = -1;
        w_log = '0;
        dr_log = '0;
        busy_log = '0;
        for (int c = 1; c < 40 && done_cyc < 0; c++) begin
            @(negedge clock);
            w_log[c] = w_a;
            dr_log[c] = det_a;
            busy_log[c] = busy_a;
            if (done_a) done_cyc = c;
            start_a = (c == p1) || (c == p2);
            data_a = start_a ? ~word : word;
        end
        @(posedge clock);
        #1;
        done_after = done_a;
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_chk++;
        if ({busy_a, done_a, found_a, first_pos_a, match_count_a, w_a} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {busy_a, done_a, found_a, first_pos_a, match_count_a, w_a});
        end
        n_chk++;
        if (det_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_det_reset: got %b want 1", det_a);
        end
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if ({det_a, busy_a, done_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want 000", {det_a, busy_a, done_a});
        end
    endtask

    task automatic check_scan_a(input string nm, input logic [7:0] word);
        res_t e;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb_empty: got 0 entries want 1", nm);
            return;
        end
        e = sb_q.pop_front();
        n_chk++;
        if (done_cyc !== 10) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d want 10", nm, done_cyc);
        end
        n_chk++;
        if (done_after !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_width: got %b want 0", nm, done_after);
        end
        n_chk++;
        if (found_a !== e.found) begin
            n_fail++;
            $display("FAIL %s_found: got %b want %0d", nm, found_a, e.found);
        end
        n_chk++;
        if (int'(first_pos_a) !== e.pos) begin
            n_fail++;
            $display("FAIL %s_first_pos: got %0d want %0d", nm, first_pos_a, e.pos);
        end
        n_chk++;
        if (int'(match_count_a) !== e.cnt) begin
            n_fail++;
            $display("FAIL %s_match_count: got %0d want %0d", nm, match_count_a, e.cnt);
        end
        for (int c = 1; c <= 10; c++) begin
            logic wexp;
            wexp = (c >= 2 && c <= 9) ? word[9-c] : 1'b0;
            n_chk++;
            if (w_log[c] !== wexp || dr_log[c] !== (c == 1) || busy_log[c] !== (c <= 9)) begin
                n_fail++;
                $display("FAIL %s_cycle%0d: got w=%b dr=%b busy=%b want w=%b dr=%b busy=%b",
                         nm, c, w_log[c], dr_log[c], busy_log[c], wexp, (c == 1), (c <= 9));
            end
        end
    endtask

    task automatic test_two_match();
        sb_q.push_back(ref_scan({8'h00, 8'b11011101}, 8, 15));
        scan_a(8'b11011101, 0, 0);
        check_scan_a("two_match", 8'b11011101);
    endtask

    task automatic test_zero();
        sb_q.push_back(ref_scan(16'h0000, 8, 15));
        scan_a(8'h00, 0, 0);
        check_scan_a("zero", 8'h00);
        n_chk++;
        if (w_log !== '0) begin
            n_fail++;
            $display("FAIL zero_w_out: got %h want 0", w_log);
        end
    endtask

    task automatic test_single();
        sb_q.push_back(ref_scan({8'h00, 8'b11111101}, 8, 15));
        scan_a(8'b11111101, 0, 0);
        check_scan_a("single", 8'b11111101);
    endtask

    task automatic test_busy_ignore();
        // Re-pulses at SHIFT k=2 (cycle 4) and in DONE (cycle 10) are dropped
        sb_q.push_back(ref_scan({8'h00, 8'b11011101}, 8, 15));
        scan_a(8'b11011101, 4, 10);
        check_scan_a("busy_ignore", 8'b11011101);
        // Start in the very next IDLE cycle must be taken
        sb_q.push_back(ref_scan({8'h00, 8'b11111101}, 8, 15));
        scan_a(8'b11111101, 0, 0);
        check_scan_a("back_to_back", 8'b11111101);
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        @(negedge clock);
        data_a = 8'b11011101;
        start_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            start_a = 1'b0;
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (det_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_det: got det=%b busy=%b want det=1 busy=1", det_a, busy_a);
        end
        @(negedge clock);
        n_chk++;
        if ({busy_a, found_a, match_count_a, first_pos_a, done_a, w_a} !== 11'b0) begin
            n_fail++;
            $display("FAIL midreset_cleared: got %b want 0", {busy_a, found_a, match_count_a, first_pos_a, done_a, w_a});
        end
        reset = 1'b0;
        done_seen = 1'b0;
        repeat (15) begin
            @(negedge clock);
            if (done_a || busy_a) done_seen = 1'b1;
        end
        n_chk++;
        if (done_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %b want 0", done_seen);
        end
        sb_q.push_back(ref_scan({8'h00, 8'b11011101}, 8, 15));
        scan_a(8'b11011101, 0, 0);
        check_scan_a("after_reset", 8'b11011101);
    endtask

    task automatic test_saturation();
        int cyc;
        res_t e;
        sb_q.push_back(ref_scan(16'hDDDD, 16, 3));
        @(negedge clock);
        data_b = 16'hDDDD;
        start_b = 1'b1;
        cyc = -1;
        for (int c = 1; c < 40 && cyc < 0; c++) begin
            @(negedge clock);
            start_b = 1'b0;
            if (done_b) cyc = c;
        end
        e = sb_q.pop_front();
        n_chk++;
        if (cyc !== 18) begin
            n_fail++;
            $display("FAIL sat_done_cycle: got %0d want 18", cyc);
        end
        n_chk++;
        if (found_b !== e.found || int'(first_pos_b) !== e.pos) begin
            n_fail++;
            $display("FAIL sat_first: got found=%b pos=%0d want found=%0d pos=%0d", found_b, first_pos_b, e.found, e.pos);
        end
        n_chk++;
        if (int'(match_count_b) !== e.cnt) begin
            n_fail++;
            $display("FAIL sat_count: got %0d want %0d", match_count_b, e.cnt);
        end
    endtask

    initial begin
        test_reset();
        test_two_match();
        test_zero();
        test_single();
        test_busy_ignore();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Sequencing controller for the team's serial 1-1-0-1 Mealy sequence detector. It accepts a parallel WIDTH-bit word on a start strobe, clears the detector, and shifts the word into the detector's serial input MSB-first, one bit per clock. It samples the detector's Mealy output each shift cycle, counts matches, records the position of the first match, and signals completion. It sits between a parallel-data producer and one detector instance.

Parameters:
WIDTH, 8, number of bits per scanned word
POS_W, 3, width of first_pos; must satisfy 2^POS_W >= WIDTH
CNT_W, 4, width of match_count; the counter saturates at 2^CNT_W-1

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to scan data_in; accepted only in IDLE
data_in  input  WIDTH  word to scan; captured on the accepting edge
busy  output  1  high in CLEAR and SHIFT
w_out  output  1  serial bit to the detector's w input
det_reset  output  1  drives the detector's synchronous reset
z_in  input  1  detector output z, combinational in w and detector state
done  output  1  one-cycle pulse; results are valid from this cycle
found  output  1  at least one match occurred in the last scan
first_pos  output  POS_W  shift index (0 = MSB) of the bit that completed the first match
match_count  output  CNT_W  number of matches in the last scan, saturating

Behaviour:
- Single clock domain. Reset is synchronous and active-high. The clock and reset ports are named clock and reset.
- States: IDLE, CLEAR, SHIFT, DONE. State is registered. Outputs other than w_out and det_reset are registered.
- Values during and after reset: state=IDLE, busy=0, done=0, found=0, first_pos=0, match_count=0, shift index=0. det_reset=1 whenever reset=1.
- IDLE: if start=1 at an edge, capture data_in into the shift register and go to CLEAR. Otherwise stay in IDLE.
- CLEAR (1 cycle):
  - det_reset=1, w_out=0, busy=1.
  - At the exiting edge, clear found, first_pos, match_count and the index, then go to SHIFT.
- SHIFT (exactly WIDTH cycles, index k = 0..WIDTH-1):
  - w_out = shift_reg[WIDTH-1]. Shift left by one at each edge.
  - Because the detector is Mealy, z_in is sampled in the same cycle as the bit it responds to.
  - On each edge with z_in=1: match_count increments, saturating at 2^CNT_W-1. If found=0, set found=1 and first_pos=k.
  - After the k=WIDTH-1 edge, go to DONE.
- DONE (1 cycle): done=1, busy=0, then return to IDLE.
- w_out=0 in every state except SHIFT. det_reset=0 except in CLEAR or during reset.
- z_in is ignored outside SHIFT.
- Latency: start accepted at edge 0; CLEAR is cycle 1; SHIFT is cycles 2..WIDTH+1; done=1 in cycle WIDTH+2. The next start is accepted at the earliest on the edge ending cycle WIDTH+3 (IDLE).
- start is ignored in CLEAR, SHIFT and DONE. It is not queued.
- found, first_pos and match_count hold their values after DONE until the next CLEAR.
- Reset mid-operation: the block returns to IDLE next cycle, results are cleared, and any partial scan is discarded. The detector is reset through det_reset at the same time.
- Matches are counted as the detector reports them. After a match the detector returns to its initial state, so it does not overlap bits between matches. The controller does not filter matches.

Test Plan:
- Bench connects w_out/z_in/det_reset to the team's 1-1-0-1 detector, with WIDTH=8. data_in=8'b11011101 -> z_in pulses at k=3 and k=7. At done: found=1, first_pos=3, match_count=2. done is high exactly in cycle 10 after start.
- data_in=8'b00000000 -> done at cycle 10. found=0, first_pos=0, match_count=0. w_out=0 throughout.
- data_in=8'b11111101 -> single match at k=7. found=1, first_pos=7, match_count=1.
- Saturation with WIDTH=16, CNT_W=2, POS_W=4: data_in=16'hDDDD -> four z pulses. match_count=3 (saturated), first_pos=3, done at cycle 18.
- Start while busy: pulse start with a new word at SHIFT k=2 and in the DONE cycle -> both ignored. Results reflect only the first word. A start in the following IDLE cycle is accepted.
- Reset at SHIFT k=3 -> next cycle: IDLE, busy=0, found=0, match_count=0, done never pulses. det_reset=1 during reset. A new start then completes normally with correct results.
